rs5_div_unit: RTL and testbench

- Multi-cycle radix-2 restoring divider: the responder that executes DIV, DIVU, REM and REMU requests issued by the execute stage.
- Sits beside the ALU in execute. Takes one request through a start/busy/done handshake and returns one 32-bit result.
- Sequencing uses the shared div_states_e encoding (D_IDLE, D_INIT, D_CALC, D_SIGN).

---
 rtl/RS5_pkg.sv | 23 ++
 rtl/rs5_div_unit.sv | 130 +++++++++++++
 tb/tb_rs5_div_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/RS5_pkg.sv
// Shared RS5 core types: divider sequencing states and one-hot instruction codes.
package RS5_pkg;

  typedef enum logic [1:0] {
    D_IDLE,
    D_INIT,
    D_CALC,
    D_SIGN
  } div_states_e;

  // One-hot instruction codes; only the divider-relevant subset is listed here.
  typedef enum logic [51:0] {
    NOP  = 52'h0_0000_0000_0000,
    ADD  = 52'h0_0000_0000_0001,
    SUB  = 52'h0_0000_0000_0002,
    MUL  = 52'h0_0800_0000_0000,
    DIV  = 52'h0_1000_0000_0000,
    DIVU = 52'h0_2000_0000_0000,
    REM  = 52'h0_4000_0000_0000,
    REMU = 52'h0_8000_0000_0000
  } iType_e;

endpackage

// File: rtl/rs5_div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU with start/busy/done handshake.
module rs5_div_unit
  import RS5_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [51:0]     op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CW = $clog2(XLEN);

  div_states_e     r_state, w_next;
  logic            r_signed, r_is_rem, r_neg_q, r_neg_r;
  logic [XLEN-1:0] r_dividend, r_divisor, r_quo, r_rem, r_result;
  logic [CW-1:0]   r_cnt;

  logic            w_legal, w_accept, w_ovf, w_special, w_last;
  logic [XLEN-1:0] w_abs_a, w_abs_b, w_quo_step, w_rem_step, w_final;
  logic [XLEN:0]   w_shift, w_diff;

  assign w_legal  = (op_i == DIV) || (op_i == DIVU) || (op_i == REM) || (op_i == REMU);
  assign w_accept = start_i && w_legal && !kill_i;

  always_comb begin
    w_abs_a   = (r_signed && r_dividend[XLEN-1]) ? -r_dividend : r_dividend;
    w_abs_b   = (r_signed && r_divisor[XLEN-1])  ? -r_divisor  : r_divisor;
    w_ovf     = r_signed && (r_dividend == {1'b1, {(XLEN-1){1'b0}}}) && (r_divisor == '1);
    w_special = (r_divisor == '0) || w_ovf;
    w_last    = (r_cnt == CW'(XLEN-1));
    // Top bit of the trial difference is the borrow: set means divisor did not fit.
    w_shift   = {r_rem, r_quo[XLEN-1]};
    w_diff    = w_shift - {1'b0, r_divisor};
    if (w_diff[XLEN]) begin
      w_rem_step = w_shift[XLEN-1:0];
      w_quo_step = {r_quo[XLEN-2:0], 1'b0};
    end else begin
      w_rem_step = w_diff[XLEN-1:0];
      w_quo_step = {r_quo[XLEN-2:0], 1'b1};
    end
    if (r_is_rem) w_final = r_neg_r ? -r_rem : r_rem;
    else          w_final = r_neg_q ? -r_quo : r_quo;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= D_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    busy_o   = (r_state != D_IDLE);
    done_o   = 1'b0;
    result_o = r_result;
    case (r_state)
      D_IDLE: if (w_accept) w_next = D_INIT;
      D_INIT: begin
        if (kill_i)         w_next = D_IDLE;
        else if (w_special) w_next = D_SIGN;
        else                w_next = D_CALC;
      end
      D_CALC: begin
        if (kill_i)      w_next = D_IDLE;
        else if (w_last) w_next = D_SIGN;
      end
      D_SIGN: begin
        w_next   = D_IDLE;
        done_o   = 1'b1;
        result_o = w_final;
      end
      default: w_next = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_signed   <= 1'b0;
      r_is_rem   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_result   <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        D_IDLE: if (w_accept) begin
          r_dividend <= rs1_i;
          r_divisor  <= rs2_i;
          r_signed   <= (op_i == DIV) || (op_i == REM);
          r_is_rem   <= (op_i == REM) || (op_i == REMU);
        end
        D_INIT: begin
          // Special cases preload the final quotient/remainder and skip sign fix-up.
          if (w_special) begin
            r_quo   <= w_ovf ? r_dividend : '1;
            r_rem   <= w_ovf ? '0 : r_dividend;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
          end else begin
            r_quo     <= w_abs_a;
            r_rem     <= '0;
            r_divisor <= w_abs_b;
            r_cnt     <= '0;
            r_neg_q   <= r_signed && (r_dividend[XLEN-1] ^ r_divisor[XLEN-1]);
            r_neg_r   <= r_signed && r_dividend[XLEN-1];
          end
        end
        D_CALC: begin
          r_quo <= w_quo_step;
          r_rem <= w_rem_step;
          r_cnt <= r_cnt + 1'b1;
        end
        D_SIGN: r_result <= w_final;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rs5_div_unit.sv
// Scoreboard bench for rs5_div_unit: directed corner cases plus random ops against an arithmetic model.
module tb_rs5_div_unit;
  import RS5_pkg::*;

  localparam int unsigned XLEN = 32;

  logic              clk = 1'b0;
  logic              reset, start_i, kill_i;
  logic [51:0]       op_i;
  logic [XLEN-1:0]   rs1_i, rs2_i;
  logic              busy_o, done_o;
  logic [XLEN-1:0]   result_o;

  always #5 clk = ~clk;

  rs5_div_unit #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .kill_i   (kill_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  typedef struct {
    logic [31:0] res;
    int unsigned cyc;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endfunction

  function automatic logic [31:0] ref_res(input logic [51:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sbv;
    sa  = a;
    sbv = b;
    if (b == 32'd0) return (op == DIV || op == DIVU) ? 32'hFFFF_FFFF : a;
    if ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return (op == DIV) ? 32'h8000_0000 : 32'd0;
    if (op == DIV)  return 32'(sa / sbv);
    if (op == REM)  return 32'(sa % sbv);
    if (op == DIVU) return a / b;
    return a % b;
  endfunction

  function automatic bit ref_fast(input logic [51:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) ||
           ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done_o) begin
      if (sbq.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: got done_o=1 at cycle %0d expected no pulse", cyc);
      end else begin
        e = sbq.pop_front();
        check({e.name, "_result"}, result_o, e.res);
        check({e.name, "_latency"}, cyc, e.cyc);
      end
    end
  end

  // Called at a negedge with the unit idle; returns at the negedge of the first busy cycle.
  task automatic start_op(input logic [51:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string nm, input bit expect_it);
    exp_t e;
    start_i = 1'b1;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    if (expect_it) begin
      e.res  = ref_res(op, a, b);
      e.cyc  = cyc + 1 + (ref_fast(op, a, b) ? 1 : 33);
      e.name = nm;
      sbq.push_back(e);
    end
    @(negedge clk);
    start_i = 1'b0;
    op_i    = NOP;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) begin
      n_total++;
      $display("FAIL %s_timeout: got busy_o=1 after %0d cycles expected idle", nm, n);
    end
  endtask

  task automatic run(input logic [51:0] op, input logic [31:0] a, input logic [31:0] b, input string nm);
    start_op(op, a, b, nm, 1'b1);
    wait_idle(nm);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected $finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] prev;
    logic [51:0] rop;
    logic [31:0] ra, rb;
    int          nb;

    reset = 1'b1; start_i = 1'b0; kill_i = 1'b0; op_i = NOP; rs1_i = '0; rs2_i = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",   {31'b0, busy_o}, 32'd0);
    check("reset_done",   {31'b0, done_o}, 32'd0);
    check("reset_result", result_o, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // DIV 100/7 with start held high and operands changing while busy.
    start_op(DIV, 32'd100, 32'd7, "div_100_7", 1'b1);
    nb = 0;
    start_i = 1'b1; op_i = DIV; rs1_i = 32'd1234; rs2_i = 32'd1;
    while (busy_o && nb < 100) begin
      nb++;
      @(negedge clk);
    end
    start_i = 1'b0; op_i = NOP;
    check("busy_cycles", nb, 32'd34);
    @(negedge clk);
    check("no_relatch_busy", {31'b0, busy_o}, 32'd0);

    run(REM,  32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    run(DIVU, 32'hFFFF_FFF9, 32'd2, "divu_m7_2");
    run(DIVU, 32'h1234_5678, 32'd0, "divu_by0");
    run(REMU, 32'h1234_5678, 32'd0, "remu_by0");
    run(DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run(REM,  32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    run(DIV,  32'hFFFF_FF9C, 32'd0, "div_neg_by0");
    run(REM,  32'hFFFF_FF9C, 32'd0, "rem_neg_by0");

    // Illegal op and kill-with-start are both refused in idle.
    start_i = 1'b1; op_i = ADD; rs1_i = 32'd5; rs2_i = 32'd1;
    @(negedge clk);
    check("illegal_op_ignored", {31'b0, busy_o}, 32'd0);
    op_i = DIV; kill_i = 1'b1;
    @(negedge clk);
    check("kill_start_ignored", {31'b0, busy_o}, 32'd0);
    start_i = 1'b0; kill_i = 1'b0; op_i = NOP;

    // Kill mid-operation, then restart immediately.
    prev = result_o;
    start_op(DIV, 32'd100, 32'd7, "killed", 1'b0);
    repeat (9) @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    check("kill_busy_low", {31'b0, busy_o}, 32'd0);
    check("kill_result_held", result_o, prev);
    run(DIVU, 32'd9, 32'd3, "after_kill");

    // Reset mid-operation.
    start_op(DIV, 32'd100, 32'd7, "reset_mid", 1'b0);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_busy",   {31'b0, busy_o}, 32'd0);
    check("rst_mid_done",   {31'b0, done_o}, 32'd0);
    check("rst_mid_result", result_o, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       rop = DIV;
        1:       rop = DIVU;
        2:       rop = REM;
        default: rop = REMU;
      endcase
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 15);
        3:       rb = -$urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      run(rop, ra, rb, $sformatf("rand%0d", i));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
